// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter period sequencer.
package counter_ctrl_pkg;
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_REPS_W = 4;
  localparam int PARK_VAL   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/synchronous_counter.sv
// Shared loadable up-counter: loads data when load=1, otherwise counts up.
module synchronous_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (load) count <= data;
    else           count <= count + 1'b1;
  end
endmodule

// File: rtl/counter_period_ctrl.sv
// Sequencer that runs the shared counter over reps periods of start_val..end_val.
// Optional watchdog (err output, shadow count) under COUNTER_PERIOD_CTRL_WATCHDOG_EN.
module counter_period_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int REPS_W = DEF_REPS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  start_val,
  input  logic [WIDTH-1:0]  end_val,
  input  logic [REPS_W-1:0] reps,
  output logic              busy,
  output logic              tick,
  output logic              done,
  output logic              cnt_load,
  output logic [WIDTH-1:0]  cnt_data,
  input  logic [WIDTH-1:0]  cnt_count
`ifdef COUNTER_PERIOD_CTRL_WATCHDOG_EN
  ,
  output logic              err
`endif
);
  state_t              state_q;
  logic [WIDTH-1:0]    sv_q, ev_q;
  logic [REPS_W-1:0]   reps_q, rep_q;
  logic                at_end, last, wd_miss, accept;

  assign at_end = (cnt_count == ev_q);
  assign last   = (rep_q == reps_q - REPS_W'(1));
  assign accept = (state_q == IDLE) && start && !abort;

`ifdef COUNTER_PERIOD_CTRL_WATCHDOG_EN
  logic [WIDTH-1:0] exp_q;
  logic             err_q;

  assign wd_miss = (state_q == RUN) && (cnt_count != exp_q);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == LOAD)     exp_q <= sv_q;
      else if (state_q == RUN) exp_q <= at_end ? sv_q : exp_q + 1'b1;
      if (accept)                                        err_q <= 1'b0;
      else if (state_q == RUN && !abort && wd_miss)      err_q <= 1'b1;
    end
  end
`else
  assign wd_miss = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sv_q    <= '0;
      ev_q    <= '0;
      reps_q  <= '0;
      rep_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          rep_q <= '0;
          if (reps != '0) begin
            sv_q    <= start_val;
            ev_q    <= end_val;
            reps_q  <= reps;
            state_q <= LOAD;
          end else begin
            state_q <= DONE;
          end
        end
        LOAD: state_q <= abort ? IDLE : RUN;
        RUN: begin
          if (abort)        state_q <= IDLE;
          else if (wd_miss) state_q <= DONE;
          else if (at_end) begin
            rep_q <= rep_q + 1'b1;
            if (last) state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state; only cnt_count feeds in combinationally.
  always_comb begin
    busy     = (state_q == LOAD) || (state_q == RUN);
    tick     = (state_q == RUN) && at_end;
    done     = (state_q == DONE);
    cnt_load = 1'b1;
    cnt_data = WIDTH'(PARK_VAL);
    case (state_q)
      LOAD: cnt_data = sv_q;
      RUN: begin
        if (!wd_miss) begin
          if (!at_end)   cnt_load = 1'b0;
          else if (!last) cnt_data = sv_q;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_counter_period_ctrl.sv
// Directed bench: sequencer closed-loop with synchronous_counter, table-driven rows.
module tb_counter_period_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] start_val, end_val, reps;
  logic       busy, tick, done, cnt_load;
  logic [3:0] cnt_data, cnt_count;
`ifdef COUNTER_PERIOD_CTRL_WATCHDOG_EN
  logic       err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  counter_period_ctrl #(.WIDTH(4), .REPS_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .start_val(start_val), .end_val(end_val), .reps(reps),
    .busy(busy), .tick(tick), .done(done),
    .cnt_load(cnt_load), .cnt_data(cnt_data), .cnt_count(cnt_count)
`ifdef COUNTER_PERIOD_CTRL_WATCHDOG_EN
    , .err(err)
`endif
  );

  synchronous_counter #(.WIDTH(4)) u_cnt (
    .clk(clk), .rst(rst), .load(cnt_load), .data(cnt_data), .count(cnt_count)
  );

  // Inputs applied before an edge; expected outputs observed just after it.
  typedef struct {
    logic       rst, start, abort;
    logic [3:0] sv, ev, rp;
    logic       busy, tick, done;
    logic [3:0] cnt;
  } vec_t;
  vec_t v[$];

  task automatic add(input logic r, s, a, input logic [3:0] sv, ev, rp,
                     input logic b, t, d, input logic [3:0] c);
    vec_t x;
    x.rst = r; x.start = s; x.abort = a; x.sv = sv; x.ev = ev; x.rp = rp;
    x.busy = b; x.tick = t; x.done = d; x.cnt = c;
    v.push_back(x);
  endtask

  task automatic st(input logic b, t, d, input logic [3:0] c);
    add(0, 0, 0, 4'd0, 4'd0, 4'd0, b, t, d, c);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive(input logic r, s, a, input logic [3:0] sv, ev, rp);
    rst = r; start = s; abort = a; start_val = sv; end_val = ev; reps = rp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 4'd0, 4'd0, 4'd0);

    // Reset state: idle, parked
    add(1, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd0);
    // 1: 3..6 twice
    add(0, 1, 0, 4'd3, 4'd6, 4'd2, 1, 0, 0, 4'd0);
    st(1, 0, 0, 4'd3); st(1, 0, 0, 4'd4); st(1, 0, 0, 4'd5); st(1, 1, 0, 4'd6);
    st(1, 0, 0, 4'd3); st(1, 0, 0, 4'd4); st(1, 0, 0, 4'd5); st(1, 1, 0, 4'd6);
    st(0, 0, 1, 4'd0); st(0, 0, 0, 4'd0);
    // 2: wrap 14,15,0,1
    add(0, 1, 0, 4'd14, 4'd1, 4'd1, 1, 0, 0, 4'd0);
    st(1, 0, 0, 4'd14); st(1, 0, 0, 4'd15); st(1, 0, 0, 4'd0); st(1, 1, 0, 4'd1);
    st(0, 0, 1, 4'd0); st(0, 0, 0, 4'd0);
    // 3: 1-cycle periods
    add(0, 1, 0, 4'd5, 4'd5, 4'd3, 1, 0, 0, 4'd0);
    st(1, 1, 0, 4'd5); st(1, 1, 0, 4'd5); st(1, 1, 0, 4'd5);
    st(0, 0, 1, 4'd0); st(0, 0, 0, 4'd0);
    // 4: reps=0 goes straight to DONE; start in DONE ignored, then accepted
    add(0, 1, 0, 4'd7, 4'd9, 4'd0, 0, 0, 1, 4'd0);
    add(0, 1, 0, 4'd1, 4'd1, 4'd1, 0, 0, 0, 4'd0);
    add(0, 1, 0, 4'd1, 4'd1, 4'd1, 1, 0, 0, 4'd0);
    st(1, 1, 0, 4'd1); st(0, 0, 1, 4'd0); st(0, 0, 0, 4'd0);
    // 5: abort at count 7 of period 2; counter already stepped to 8, parked next
    add(0, 1, 0, 4'd0, 4'd9, 4'd4, 1, 0, 0, 4'd0);
    for (int i = 0; i < 10; i++) st(1, (i == 9), 0, 4'(i));
    for (int i = 0; i < 8; i++)  st(1, 0, 0, 4'(i));
    add(0, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd8);
    st(0, 0, 0, 4'd0);
    // abort+start in IDLE: abort wins
    add(0, 1, 1, 4'd2, 4'd3, 4'd1, 0, 0, 0, 4'd0);
    add(0, 1, 0, 4'd2, 4'd3, 4'd1, 1, 0, 0, 4'd0);
    st(1, 0, 0, 4'd2); st(1, 1, 0, 4'd3); st(0, 0, 1, 4'd0); st(0, 0, 0, 4'd0);

    foreach (v[i]) begin
      drive(v[i].rst, v[i].start, v[i].abort, v[i].sv, v[i].ev, v[i].rp);
      chk($sformatf("row%0d{busy,tick,done,cnt}", i),
          {9'd0, busy, tick, done, cnt_count},
          {9'd0, v[i].busy, v[i].tick, v[i].done, v[i].cnt});
    end

    // 6: extra starts during RUN and config changes ignored, then rst mid-RUN
    drive(0, 1, 0, 4'd1, 4'd2, 4'd2);
    chk("seq6_load", {12'd0, busy, tick, done, 1'b0} | {8'd0, cnt_count, 4'd0}, 16'h0008);
    drive(0, 1, 0, 4'd9, 4'd9, 4'd9);
    chk("seq6_run1_cnt", {12'd0, cnt_count}, 16'h0001);
    chk("seq6_run1_tick", {15'd0, tick}, 16'h0000);
    drive(0, 1, 0, 4'd9, 4'd9, 4'd9);
    chk("seq6_run2_cnt", {12'd0, cnt_count}, 16'h0002);
    chk("seq6_run2_tick", {15'd0, tick}, 16'h0001);
    chk("seq6_run2_reload", {11'd0, cnt_load, cnt_data}, 16'h0011);
    drive(0, 0, 0, 4'd0, 4'd0, 4'd0);
    chk("seq6_run3_cnt", {12'd0, cnt_count}, 16'h0001);
    drive(1, 1, 0, 4'd3, 4'd4, 4'd5);
    chk("seq6_rst_outs", {10'd0, busy, tick, done, cnt_load, 2'd0}, 16'h0004);
    chk("seq6_rst_data_cnt", {8'd0, cnt_data, cnt_count}, 16'h0000);
    drive(0, 0, 0, 4'd0, 4'd0, 4'd0);
    chk("seq6_idle_after_rst", {11'd0, busy, cnt_count}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/counter_period_ctrl.md
Name: counter_period_ctrl

Overview:
Sequencer for the shared loadable up-counter (synchronous_counter: rst/load/data/count, counts up every cycle when load=0).
- Starts the counter at a programmed value.
- Detects a programmed terminal count and reloads the counter, giving a fixed number of repeating periods.
- Emits one tick per period and a done pulse at the end.
- Parks the counter at 0 when idle.

Parameters:
WIDTH, 4, counter width; must match the counter instance.
REPS_W, 4, width of the period-repeat count.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
abort  in  1  synchronous abort; returns to IDLE without done.
start_val  in  WIDTH  value loaded at the start of each period.
end_val  in  WIDTH  terminal count closing each period.
reps  in  REPS_W  number of periods to run.
busy  out  1  high in LOAD and RUN.
tick  out  1  one-cycle pulse on the cycle cnt_count==end_val in RUN.
done  out  1  one-cycle pulse after the final period.
cnt_load  out  1  drives counter load.
cnt_data  out  WIDTH  drives counter data.
cnt_count  in  WIDTH  counter output.

Behaviour:
- Reset: state IDLE, busy=0, tick=0, done=0, cnt_load=1, cnt_data=0, rep counter=0, latched configuration=0. rst has priority over all inputs.
- IDLE: cnt_load=1, cnt_data=0, which holds the counter at 0.
- IDLE, start=1, reps!=0: latch start_val, end_val and reps; go to LOAD.
- IDLE, start=1, reps==0: go to DONE directly; no LOAD, no tick.
- LOAD (1 cycle): cnt_load=1, cnt_data=start_val_q; go to RUN. Counter shows start_val in the first RUN cycle.
- RUN, cnt_count!=end_val_q: cnt_load=0; counter increments.
- RUN, cnt_count==end_val_q:
  - tick=1 in that cycle; rep counter increments.
  - If this was not the final period: cnt_load=1, cnt_data=start_val_q, stay in RUN. Next cycle count=start_val, so there is no dead cycle between periods.
  - If it was the final period (rep counter==reps_q-1): go to DONE with cnt_load=1, cnt_data=0.
- Period length is ((end_val - start_val) mod 2^WIDTH) + 1 cycles; wrap-around through 0 is legal. start_val==end_val gives a 1-cycle period with tick every cycle.
- DONE (1 cycle): done=1, busy=0, cnt_load=1, cnt_data=0; go to IDLE.
- start while not in IDLE: ignored. Configuration inputs are ignored after latching.
- abort in LOAD, RUN or DONE: next state IDLE, no done pulse, counter parked at 0. abort in IDLE has no effect. abort and start together in IDLE: abort wins, start is ignored.
- start in the DONE cycle is ignored; a new start is accepted from the following IDLE cycle.
- All outputs are decoded from registered state and registered configuration, plus the single cnt_count compare. No combinational path from start or abort to outputs.

Optional Feature:
Macro COUNTER_PERIOD_CTRL_WATCHDOG_EN.
- With the macro defined:
  - Adds output err (1 bit).
  - A shadow register tracks the expected count. In RUN, any cnt_count != expected sets err sticky and forces a transition to DONE.
  - err clears on rst or on the next accepted start.
- Without the macro: the err port and shadow logic are absent; behaviour is otherwise identical.

Decomposition:
- Package counter_ctrl_pkg holds:
  - state encoding localparams: IDLE, LOAD, RUN, DONE.
  - default WIDTH/REPS_W constants.
  - PARK_VAL=0.
- No sub-module. The FSM, repeat counter and compare are small enough to stay in one module.
- The bench instantiates the block with synchronous_counter to close the loop.

Test Plan:
1. start_val=3, end_val=6, reps=2 -> count 3,4,5,6,3,4,5,6; tick on both 6s (4 cycles apart); done 1 cycle after the second tick; count 0 afterwards.
2. start_val=14, end_val=1, reps=1 -> count 14,15,0,1; a single tick at 1; done next cycle (wrap-around).
3. start_val=5, end_val=5, reps=3 -> tick on 3 consecutive RUN cycles with count=5 throughout; then done.
4. reps=0 with start -> done exactly 1 cycle later; busy never high; no tick; counter stays 0.
5. start_val=0, end_val=9, reps=4; abort at count 7 of period 2 -> IDLE next cycle, no done, count 0. A re-issued start runs normally.
6. start pulses during RUN and rst mid-RUN -> extra start ignored; on rst all outputs return to reset values and the counter is 0.
